spi_reg_bank: RTL and testbench

//  Parametrised SPI-mode-0 peripheral with an N-entry register bank, successor to the fixed 5x8 write-only bank.

---
 rtl/spi_reg_pkg.sv | 30 +++
 rtl/spi_sync_edge.sv | 38 +++
 rtl/spi_reg_bank.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_reg_bank.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and sizing helpers for the SPI register bank.
// Frame/counter widths are functions so each instance sizes itself.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Frame = rw bit + address field + data field.
    function automatic int frame_w(
        input int addr_w,
        input int data_w
    );
        return 1 + addr_w + data_w;
    endfunction

    // Bit counter must hold FRAME_W+1 (overlength marker).
    function automatic int cnt_w(
        input int addr_w,
        input int data_w
    );
        return $clog2(frame_w(addr_w, data_w) + 2);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall pulses.
// Ports: clk, rst_n, din (async pin) -> level, rise, fall (clk domain).
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    // Edges are suppressed until both level and prev_q hold real
    // pin samples, so a pin already asserted at reset release
    // never looks like a fresh edge.
    logic [STAGES:0]   vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            vld_q  <= {vld_q[STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = vld_q[STAGES] & level & ~prev_q;
    assign fall  = vld_q[STAGES] & ~level & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral writing an N-entry register bank.
// Define SPI_READBACK_EN to enable register readback on CIPO.
// Ports: clk, rst_n; SCLK, cs, COPI pins; CIPO, cipo_oe readback;
//   regs_flat bank; wr_strobe, wr_addr commit info; frame_err pulse.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCLK,
    input  logic                       cs,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = cnt_w(ADDR_W, DATA_W);

    localparam logic [CNT_W-1:0] CNT_FULL =
        CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVER =
        CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W:0] NREGS =
        (ADDR_W+1)'(NUM_REGS);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic copi_lvl, copi_rise, copi_fall;

    spi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b0)
    ) u_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (SCLK),
        .level(sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b1)
    ) u_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (cs),
        .level(cs_lvl),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b0)
    ) u_copi (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (COPI),
        .level(copi_lvl),
        .rise (copi_rise),
        .fall (copi_fall)
    );

    state_t state, state_nxt;

    logic [FRAME_W-1:0] sr;
    logic [CNT_W-1:0]   bit_cnt;

    logic              f_rw;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_data;
    logic              full;
    logic              in_range;
    logic              do_wr;
    logic              bad;
    logic              shift_en;
    logic              commit_en;

    assign f_rw     = sr[FRAME_W-1];
    assign f_addr   = sr[DATA_W +: ADDR_W];
    assign f_data   = sr[DATA_W-1:0];
    assign full     = (bit_cnt == CNT_FULL);
    assign in_range = ({1'b0, f_addr} < NREGS);
    assign do_wr    = full && (f_rw == RW_WRITE)
                      && in_range;
    assign bad      = !full
                      || ((f_rw != RW_READ) && !in_range);

    // cs edges take priority over a coincident SCLK edge.
    assign shift_en  = (state == SHIFT) && sclk_rise
                       && !cs_fall && !cs_rise;
    assign commit_en = (state == SHIFT) && cs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cs_fall) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cs_rise) state_nxt = COMMIT;
            end
            COMMIT: begin
                state_nxt = cs_fall ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shifter, bit counter and commit pulses.  The commit decision
    // is taken on the cs rise, so the bank and pulses update on the
    // edge that enters COMMIT and the pulses last that one state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            bit_cnt   <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            unique case (1'b1)
                cs_fall: begin
                    sr      <= '0;
                    bit_cnt <= '0;
                end
                shift_en: begin
                    sr <= {sr[FRAME_W-2:0], copi_lvl};
                    if (bit_cnt != CNT_OVER)
                        bit_cnt <= bit_cnt + 1'b1;
                end
                commit_en: begin
                    wr_strobe <= do_wr;
                    frame_err <= bad;
                    if (do_wr) wr_addr <= f_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_flat <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_en && do_wr
                    && f_addr == ADDR_W'(i))
                    regs_flat[i*DATA_W +: DATA_W] <= f_data;
            end
        end
    end

`ifdef SPI_READBACK_EN
    localparam logic [CNT_W-1:0] CNT_HDR =
        CNT_W'(1 + ADDR_W);

    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rd_data;
    logic              tx_loaded;
    logic              tx_load;
    logic              oe_q;
    logic              cipo_q;

    // Header is complete: addr sits in the low bits, rw above it.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sr[ADDR_W-1:0] == ADDR_W'(i))
                rd_data = regs_flat[i*DATA_W +: DATA_W];
        end
    end

    assign tx_load = (state == SHIFT) && !tx_loaded
                     && (bit_cnt == CNT_HDR)
                     && (sr[ADDR_W] == RW_READ)
                     && !cs_fall && !cs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr     <= '0;
            tx_loaded <= 1'b0;
            oe_q      <= 1'b0;
            cipo_q    <= 1'b0;
        end else if (cs_fall || cs_rise) begin
            tx_loaded <= 1'b0;
            oe_q      <= 1'b0;
            cipo_q    <= 1'b0;
        end else if (tx_load) begin
            tx_sr     <= rd_data;
            tx_loaded <= 1'b1;
            oe_q      <= 1'b1;
            cipo_q    <= 1'b0;
        end else if (oe_q && sclk_fall) begin
            cipo_q <= tx_sr[DATA_W-1];
            tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo_oe = oe_q;
    assign CIPO    = oe_q & cipo_q;

    logic unused_sig;
    assign unused_sig = ^{sclk_lvl, cs_lvl,
                          copi_rise, copi_fall};
`else
    assign cipo_oe = 1'b0;
    assign CIPO    = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{sclk_lvl, sclk_fall, cs_lvl,
                          copi_rise, copi_fall};
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: table, hand-written and random frames against a
// frame-level model, on a default instance and a 16x16 instance.
module tb_spi_reg_bank;

    logic clk;
    logic rst_n;
    logic sclk_p [2];
    logic cs_p   [2];
    logic copi_p [2];

    logic         cipo_a, oe_a, wrs_a, err_a;
    logic [39:0]  regs_a;
    logic [6:0]   wa_a;
    logic         cipo_b, oe_b, wrs_b, err_b;
    logic [255:0] regs_b;
    logic [6:0]   wa_b;

    spi_reg_bank #(
        .NUM_REGS(5), .DATA_W(8),
        .ADDR_W(7), .SYNC_STAGES(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .SCLK(sclk_p[0]), .cs(cs_p[0]), .COPI(copi_p[0]),
        .CIPO(cipo_a), .cipo_oe(oe_a),
        .regs_flat(regs_a), .wr_strobe(wrs_a),
        .wr_addr(wa_a), .frame_err(err_a)
    );

    spi_reg_bank #(
        .NUM_REGS(16), .DATA_W(16),
        .ADDR_W(7), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .SCLK(sclk_p[1]), .cs(cs_p[1]), .COPI(copi_p[1]),
        .CIPO(cipo_b), .cipo_oe(oe_b),
        .regs_flat(regs_b), .wr_strobe(wrs_b),
        .wr_addr(wa_b), .frame_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nwr [2] = '{0, 0};
    int nerr[2] = '{0, 0};

    // Pulse monitors: count clock cycles each pulse is high.
    always @(negedge clk) begin
        if (wrs_a) nwr[0]  += 1;
        if (err_a) nerr[0] += 1;
        if (wrs_b) nwr[1]  += 1;
        if (err_b) nerr[1] += 1;
    end

    // Reference model: register contents and last written address.
    logic [7:0]  ma [5];
    logic [15:0] mb [16];
    int          exp_wa [2];
    logic        smp_cipo [64];
    logic        smp_oe   [64];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int hh(input int half, input bit jit);
        return half + (jit ? int'($urandom_range(0, 1)) : 0);
    endfunction

    task automatic model_reset();
        foreach (ma[i]) ma[i] = '0;
        foreach (mb[i]) mb[i] = '0;
        exp_wa[0] = 0;
        exp_wa[1] = 0;
    endtask

    // Frame rules: exact length, rw=1 and addr in range writes;
    // wrong length or bad write address is an error; a full-length
    // read does nothing visible on the bank.
    task automatic model_frame(input int d,
                               input logic [63:0] bits,
                               input int n,
                               output int mw,
                               output int me);
        int fw, dw, nr, addr;
        logic rw;
        logic [15:0] data;
        fw = (d == 0) ? 16 : 24;
        dw = (d == 0) ? 8 : 16;
        nr = (d == 0) ? 5 : 16;
        rw = bits[fw-1];
        addr = int'((bits >> dw) & 64'h7F);
        data = 16'(bits & ((64'd1 << dw) - 1));
        mw = 0;
        me = 0;
        if (n != fw) begin
            me = 1;
        end else if (rw) begin
            if (addr < nr) begin
                mw = 1;
                if (d == 0) ma[addr] = data[7:0];
                else        mb[addr] = data;
                exp_wa[d] = addr;
            end else begin
                me = 1;
            end
        end
    endtask

    task automatic chk_bank(input int d, input string name);
        logic [255:0] e;
        e = '0;
        if (d == 0) begin
            for (int i = 0; i < 5; i++) e[i*8 +: 8] = ma[i];
            chk({name, "/bank"}, {216'd0, regs_a}, e);
            chk({name, "/wr_addr"}, {249'd0, wa_a},
                256'(exp_wa[0]));
        end else begin
            for (int i = 0; i < 16; i++)
                e[i*16 +: 16] = mb[i];
            chk({name, "/bank"}, regs_b, e);
            chk({name, "/wr_addr"}, {249'd0, wa_b},
                256'(exp_wa[1]));
        end
    endtask

    task automatic shift_bits(input int d,
                              input logic [63:0] bits,
                              input int n,
                              input int half,
                              input bit jit);
        for (int i = n - 1; i >= 0; i--) begin
            copi_p[d] = bits[i];
            wait_clk(hh(half, jit));
            smp_cipo[n-1-i] = (d == 0) ? cipo_a : cipo_b;
            smp_oe[n-1-i]   = (d == 0) ? oe_a : oe_b;
            sclk_p[d] = 1'b1;
            wait_clk(hh(half, jit));
            sclk_p[d] = 1'b0;
        end
    endtask

    task automatic send_frame(input int d,
                              input logic [63:0] bits,
                              input int n,
                              input int half,
                              input bit jit);
        cs_p[d] = 1'b0;
        wait_clk(4);
        shift_bits(d, bits, n, half, jit);
        wait_clk(half);
        cs_p[d] = 1'b1;
        copi_p[d] = 1'b0;
        wait_clk(8);
    endtask

    task automatic chk_after(input int d, input int w0,
                             input int e0, input int ew,
                             input int ee, input string name);
        chk({name, "/wr_strobe"}, 256'(nwr[d] - w0), 256'(ew));
        chk({name, "/frame_err"}, 256'(nerr[d] - e0), 256'(ee));
        chk_bank(d, name);
    endtask

    // ew/ee < 0 take the expectation from the model.
    task automatic do_frame(input int d,
                            input logic [63:0] bits,
                            input int n, input int half,
                            input bit jit, input int ew,
                            input int ee, input string name);
        int w0, e0, mw, me;
        w0 = nwr[d];
        e0 = nerr[d];
        send_frame(d, bits, n, half, jit);
        model_frame(d, bits, n, mw, me);
        if (ew < 0) ew = mw;
        if (ee < 0) ee = me;
        chk_after(d, w0, e0, ew, ee, name);
    endtask

    typedef struct {
        int          d;
        logic [63:0] bits;
        int          n;
        int          ew;
        int          ee;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int w0, e0, mw, me;
        logic [7:0] rbv, rov;

        tbl[0]  = '{0, 64'h84A5, 16, 1, 0};
        tbl[1]  = '{0, 64'h855A, 16, 0, 1};
        tbl[2]  = '{0, 64'h2AA, 10, 0, 1};
        tbl[3]  = '{0, 64'h10233, 17, 0, 1};
        tbl[4]  = '{0, 64'hFFFF_FFFF_8277, 48, 0, 1};
        tbl[5]  = '{0, 64'h0400, 16, 0, 0};
        tbl[6]  = '{0, 64'h6400, 16, 0, 0};
        tbl[7]  = '{0, 64'h8011, 16, 1, 0};
        tbl[8]  = '{0, 64'h8022, 16, 1, 0};
        tbl[9]  = '{0, 64'hFF00, 16, 0, 1};
        tbl[10] = '{0, 64'h0, 0, 0, 1};
        tbl[11] = '{1, 64'h8FBEEF, 24, 1, 0};
        tbl[12] = '{1, 64'h901234, 24, 0, 1};
        tbl[13] = '{1, 64'h8F12, 16, 0, 1};
        tbl[14] = '{1, 64'h80CAFE, 24, 1, 0};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            sclk_p[d] = 1'b0;
            cs_p[d]   = 1'b1;
            copi_p[d] = 1'b0;
        end
        model_reset();
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(6);

        chk("reset/regs_a", {216'd0, regs_a}, '0);
        chk("reset/regs_b", regs_b, '0);
        chk("reset/pulses", {252'd0, wrs_a, err_a, wrs_b, err_b},
            '0);
        chk("reset/wr_addr", {242'd0, wa_a, wa_b}, '0);
        chk("reset/cipo", {252'd0, cipo_a, oe_a, cipo_b, oe_b},
            '0);

        for (int i = 0; i < 15; i++) begin
            do_frame(tbl[i].d, tbl[i].bits, tbl[i].n, 2, 1'b0,
                     tbl[i].ew, tbl[i].ee,
                     $sformatf("tbl%0d", i));
        end

        // cs fall together with an SCLK rise: that SCLK edge is lost.
        w0 = nwr[0];
        e0 = nerr[0];
        copi_p[0] = 1'b1;
        cs_p[0] = 1'b0;
        sclk_p[0] = 1'b1;
        wait_clk(2);
        sclk_p[0] = 1'b0;
        wait_clk(2);
        shift_bits(0, 64'h8133, 16, 2, 1'b0);
        wait_clk(2);
        cs_p[0] = 1'b1;
        copi_p[0] = 1'b0;
        wait_clk(8);
        model_frame(0, 64'h8133, 16, mw, me);
        chk_after(0, w0, e0, 1, 0, "csfall_sclk");

        // cs rise together with an SCLK rise: that SCLK edge is lost.
        w0 = nwr[0];
        e0 = nerr[0];
        cs_p[0] = 1'b0;
        wait_clk(4);
        shift_bits(0, 64'h8244, 16, 2, 1'b0);
        wait_clk(2);
        cs_p[0] = 1'b1;
        sclk_p[0] = 1'b1;
        wait_clk(2);
        sclk_p[0] = 1'b0;
        wait_clk(8);
        model_frame(0, 64'h8244, 16, mw, me);
        chk_after(0, w0, e0, 1, 0, "csrise_sclk");

        // Readback of reg2 with a slow SCLK.
        do_frame(0, 64'h82C3, 16, 2, 1'b0, 1, 0, "rb_wr");
        do_frame(0, 64'h0200, 16, 4, 1'b0, 0, 0, "rb_rd");
        for (int k = 0; k < 8; k++) begin
            rbv[7-k] = smp_cipo[8+k];
            rov[7-k] = smp_oe[8+k];
        end
`ifdef SPI_READBACK_EN
        chk("rb/cipo", 256'(rbv), 256'(8'hC3));
        chk("rb/cipo_oe", 256'(rov), 256'(8'hFF));
`else
        chk("rb/cipo", 256'(rbv), '0);
        chk("rb/cipo_oe", 256'(rov), '0);
`endif

        // Reset mid-frame with cs held low through release.
        cs_p[0] = 1'b0;
        wait_clk(4);
        shift_bits(0, 64'hA5, 8, 2, 1'b0);
        rst_n = 1'b0;
        wait_clk(3);
        model_reset();
        rst_n = 1'b1;
        wait_clk(6);
        chk("midrst/regs_a", {216'd0, regs_a}, '0);
        chk("midrst/regs_b", regs_b, '0);
        w0 = nwr[0];
        e0 = nerr[0];
        cs_p[0] = 1'b1;
        wait_clk(6);
        send_frame(0, 64'h813C, 16, 2, 1'b1);
        model_frame(0, 64'h813C, 16, mw, me);
        chk_after(0, w0, e0, 1, 0, "midrst");

        // Random frames with SCLK jitter.
        for (int it = 0; it < 40; it++) begin
            int d, fw, dw, nr, n, addr;
            logic rw;
            logic [63:0] b;
            d  = int'($urandom_range(0, 1));
            fw = (d == 0) ? 16 : 24;
            dw = (d == 0) ? 8 : 16;
            nr = (d == 0) ? 5 : 16;
            n  = ($urandom_range(0, 9) < 8) ? fw
                 : int'($urandom_range(0, fw + 3));
            rw = ($urandom_range(0, 3) != 0);
            addr = ($urandom_range(0, 4) != 0)
                   ? int'($urandom_range(0, nr - 1))
                   : int'($urandom_range(0, 127));
            b = {$urandom, $urandom};
            if (n == fw)
                b = (64'(rw) << (fw - 1))
                    | (64'(addr) << dw)
                    | (b & ((64'd1 << dw) - 1));
            do_frame(d, b, n, 2, 1'b1, -1, -1,
                     $sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
